// File: rtl/ltm_disp_reader.sv
`default_nettype none
// ============================================================================
// Module   : ltm_disp_reader
// Function : LCD timing generator and display-FIFO reader. It waits for the
//            FIFO to hold data, then runs free-running h/v counters, fetches
//            one FIFO word per active pixel, and drives sync, DEN and RGB
//            through a two-stage output pipeline. Underflowed pixels are
//            blanked and counted per frame.
// Revision : 1.0 - initial release
// ============================================================================
module ltm_disp_reader #(
  parameter int H_SYNC   = 1,
  parameter int H_BACK   = 215,
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 34,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [23:0] iFIFO_DATA,
  input  logic        iFIFO_EMPTY,
  output logic        oFIFO_RD,
  output logic [7:0]  oLCD_R,
  output logic [7:0]  oLCD_G,
  output logic [7:0]  oLCD_B,
  output logic        oHD,
  output logic        oVD,
  output logic        oDEN,
  output logic        oFRAME_START,
  output logic        oUNDERFLOW,
  output logic [15:0] oUFLOW_CNT
);

  localparam int c_H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int c_V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int c_HW      = $clog2(c_H_TOTAL);
  localparam int c_VW      = $clog2(c_V_TOTAL);

  localparam logic [c_HW-1:0] c_H_LAST      = c_HW'(c_H_TOTAL - 1);
  localparam logic [c_VW-1:0] c_V_LAST      = c_VW'(c_V_TOTAL - 1);
  localparam logic [c_HW-1:0] c_H_SYNC_END  = c_HW'(H_SYNC);
  localparam logic [c_VW-1:0] c_V_SYNC_END  = c_VW'(V_SYNC);
  localparam logic [c_HW-1:0] c_H_ACT_FIRST = c_HW'(H_SYNC + H_BACK);
  localparam logic [c_HW-1:0] c_H_ACT_LAST  = c_HW'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [c_VW-1:0] c_V_ACT_FIRST = c_VW'(V_SYNC + V_BACK);
  localparam logic [c_VW-1:0] c_V_ACT_LAST  = c_VW'(V_SYNC + V_BACK + V_ACTIVE - 1);

  typedef enum logic [0:0] {
    WAIT_FILL = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_HW-1:0] r_h;
  logic [c_VW-1:0] r_v;

  // first pipeline stage: timing decoded from counter state t
  logic            r_s1_hd;
  logic            r_s1_vd;
  logic            r_s1_den;
  logic            r_s1_rd;

  // second pipeline stage: the registered panel outputs
  logic            r_hd;
  logic            r_vd;
  logic            r_den;
  logic [23:0]     r_rgb;

  logic            r_uflow;
  logic [15:0]     r_uflow_cnt;

  logic            w_run;
  logic            w_h_act;
  logic            w_v_act;
  logic            w_active;
  logic            w_uflow;
  logic            w_frame_start;

  assign w_run         = (r_state == RUN);
  assign w_h_act       = (r_h >= c_H_ACT_FIRST) && (r_h <= c_H_ACT_LAST);
  assign w_v_act       = (r_v >= c_V_ACT_FIRST) && (r_v <= c_V_ACT_LAST);
  assign w_active      = w_run && w_h_act && w_v_act;
  assign w_uflow       = w_active && iFIFO_EMPTY;
  // Must line up with the counters, not with the delayed panel outputs
  assign w_frame_start = w_run && (r_h == '0) && (r_v == '0);

  assign oFIFO_RD      = w_active && !iFIFO_EMPTY;
  assign oFRAME_START  = w_frame_start;
  assign oHD           = r_hd;
  assign oVD           = r_vd;
  assign oDEN          = r_den;
  assign oLCD_R        = r_rgb[23:16];
  assign oLCD_G        = r_rgb[15:8];
  assign oLCD_B        = r_rgb[7:0];
  assign oUNDERFLOW    = r_uflow;
  assign oUFLOW_CNT    = r_uflow_cnt;

  // Control FSM and raster counters; counters parked at 0 until the FIFO fills
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= WAIT_FILL;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      case (r_state)
        WAIT_FILL: begin
          r_h <= '0;
          r_v <= '0;
          if (!iFIFO_EMPTY) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (r_h == c_H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == c_V_LAST) ? '0 : r_v + c_VW'(1);
          end else begin
            r_h <= r_h + c_HW'(1);
          end
        end
        default: begin
          r_state <= WAIT_FILL;
          r_h     <= '0;
          r_v     <= '0;
        end
      endcase
    end
  end

  // Stage 1: decode sync/enable from the counters; syncs stay idle-high while waiting
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_s1_hd  <= 1'b1;
      r_s1_vd  <= 1'b1;
      r_s1_den <= 1'b0;
      r_s1_rd  <= 1'b0;
    end else begin
      r_s1_hd  <= w_run ? (r_h >= c_H_SYNC_END) : 1'b1;
      r_s1_vd  <= w_run ? (r_v >= c_V_SYNC_END) : 1'b1;
      r_s1_den <= w_active;
      r_s1_rd  <= oFIFO_RD;
    end
  end

  // Stage 2: capture the FIFO word one clock after its read, black otherwise
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hd  <= 1'b1;
      r_vd  <= 1'b1;
      r_den <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hd  <= r_s1_hd;
      r_vd  <= r_s1_vd;
      r_den <= r_s1_den;
      r_rgb <= r_s1_rd ? iFIFO_DATA : 24'h000000;
    end
  end

  // Per-frame underflow flag and saturating count; an underflow on the frame-start clock wins
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_uflow     <= 1'b0;
      r_uflow_cnt <= '0;
    end else if (w_frame_start) begin
      r_uflow     <= w_uflow;
      r_uflow_cnt <= {15'd0, w_uflow};
    end else if (w_uflow) begin
      r_uflow <= 1'b1;
      if (r_uflow_cnt != 16'hFFFF) begin
        r_uflow_cnt <= r_uflow_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ltm_disp_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ltm_disp_reader
// Function : Bench for ltm_disp_reader. A small-raster instance is checked
//            every cycle against a raster model; a second instance with a
//            large active area sits on an empty FIFO to exercise counter
//            saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ltm_disp_reader;

  localparam int HS = 2, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 1, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic        hd;
    logic        vd;
    logic        den;
    logic        rd;
    logic [23:0] word;
  } rec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // small-raster DUT
  logic        rst_n;
  logic [23:0] fifo_data;
  logic        fifo_empty;
  logic        rd;
  logic [7:0]  lr, lg, lb;
  logic        hd, vd, den, fs, uf;
  logic [15:0] ucnt;

  // saturation DUT
  logic        rst2_n;
  logic [23:0] data2;
  logic        empty2;
  logic        rd2;
  logic [7:0]  lr2, lg2, lb2;
  logic        hd2, vd2, den2, fs2, uf2;
  logic [15:0] ucnt2;

  ltm_disp_reader #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) u_dut (
    .CLK(clk), .RESET_N(rst_n), .iFIFO_DATA(fifo_data), .iFIFO_EMPTY(fifo_empty),
    .oFIFO_RD(rd), .oLCD_R(lr), .oLCD_G(lg), .oLCD_B(lb),
    .oHD(hd), .oVD(vd), .oDEN(den), .oFRAME_START(fs),
    .oUNDERFLOW(uf), .oUFLOW_CNT(ucnt)
  );

  ltm_disp_reader #(
    .H_SYNC(1), .H_BACK(1), .H_ACTIVE(256), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(260), .V_FRONT(1)
  ) u_dut_sat (
    .CLK(clk), .RESET_N(rst2_n), .iFIFO_DATA(data2), .iFIFO_EMPTY(empty2),
    .oFIFO_RD(rd2), .oLCD_R(lr2), .oLCD_G(lg2), .oLCD_B(lb2),
    .oHD(hd2), .oVD(vd2), .oDEN(den2), .oFRAME_START(fs2),
    .oUNDERFLOW(uf2), .oUFLOW_CNT(ucnt2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit          m_run;
  int          m_n;
  int          m_k;
  int          m_raw;
  rec_t        p1, p2;
  logic [23:0] base;
  int          fifo_ptr;

  // frame statistics from observed outputs
  bit          f_valid;
  int          f_cyc, f_rd, f_den, f_hdlow, f_vdlow;

  // saturation DUT monitor
  int          cyc2;
  int          n_fs2;
  bit          chk_next2;
  bit          done2;
  logic [15:0] prev_cnt2;
  logic        prev_uf2;

  function automatic rec_t idle();
    rec_t r;
    r.hd = 1'b1; r.vd = 1'b1; r.den = 1'b0; r.rd = 1'b0; r.word = 24'h0;
    return r;
  endfunction

  function automatic logic [23:0] pat(input int k);
    return base + 24'(k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: apply inputs, compare every output with the model, advance the model
  task automatic cyc(input bit empty, input bit rstn);
    int   h, v;
    bit   act, exp_rd, exp_fs, ufl;
    logic obs_rd;
    rec_t cur;
    @(negedge clk);
    fifo_empty = empty;
    rst_n      = rstn;
    rst2_n     = (cyc2 >= 2);
    empty2     = (cyc2 != 2);
    #1;
    if (!rstn) begin
      m_run = 0; m_n = 0; m_raw = 0; p1 = idle(); p2 = idle(); f_valid = 0;
    end
    h      = m_run ? (m_n % HT) : 0;
    v      = m_run ? (m_n / HT) : 0;
    act    = m_run && (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
    exp_rd = act && !empty;
    ufl    = act && empty;
    exp_fs = m_run && (m_n == 0);

    chk("fifo_rd", rd, exp_rd);
    chk("frame_start", fs, exp_fs);
    chk("hd", hd, p2.hd);
    chk("vd", vd, p2.vd);
    chk("den", den, p2.den);
    chk("rgb", {lr, lg, lb}, p2.rd ? p2.word : 24'h0);
    chk("uflow_flag", uf, m_raw > 0);
    chk("uflow_cnt", ucnt, (m_raw > 65535) ? 65535 : m_raw);

    if (fs) begin
      if (f_valid) begin
        chk("frame_period", f_cyc, FRAME);
        chk("frame_den", f_den, HA * VA);
        chk("frame_fetch", f_rd + ucnt, HA * VA);
        chk("frame_hd_low", f_hdlow, HS * VT);
        chk("frame_vd_low", f_vdlow, VS * HT);
      end
      f_valid = rstn;
      f_cyc = 0; f_rd = 0; f_den = 0; f_hdlow = 0; f_vdlow = 0;
    end
    f_cyc++; f_rd += rd; f_den += den; f_hdlow += !hd; f_vdlow += !vd;

    if (chk_next2) begin
      chk("sat_cleared", ucnt2, 0);
      chk_next2 = 0;
      done2 = 1;
    end
    if (fs2) begin
      n_fs2++;
      if (n_fs2 == 2) begin
        chk("sat_cnt", prev_cnt2, 16'hFFFF);
        chk("sat_flag", prev_uf2, 1);
        chk_next2 = 1;
      end
    end
    prev_cnt2 = ucnt2;
    prev_uf2  = uf2;

    cur = idle();
    if (m_run) begin
      cur.hd = (h >= HS); cur.vd = (v >= VS); cur.den = act; cur.rd = exp_rd;
      cur.word = pat(m_k);
      if (exp_rd) m_k++;
    end
    if (rstn) begin
      if (exp_fs) m_raw = ufl ? 1 : 0;
      else if (ufl) m_raw++;
      if (!m_run) begin
        if (!empty) m_run = 1;
        m_n = 0;
      end else begin
        m_n = (m_n + 1) % FRAME;
      end
      p2 = p1;
      p1 = cur;
    end
    obs_rd = rd;
    @(posedge clk);
    #1;
    if (obs_rd) begin
      fifo_data = pat(fifo_ptr);
      fifo_ptr++;
    end
    cyc2++;
  endtask

  // advance until the model's next cycle sits at raster index target
  task automatic run_to(input int target, input bit rnd);
    int guard = 0;
    while (!(m_run && m_n == target) && guard < 2 * FRAME) begin
      cyc(rnd ? ($urandom_range(0, 3) == 0) : 1'b0, 1'b1);
      guard++;
    end
    chk("run_to_bound", guard < 2 * FRAME, 1);
  endtask

  initial begin
    int guard;
    base = 24'($urandom);
    fifo_data = 24'($urandom);
    fifo_empty = 1'b1;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    empty2 = 1'b1;
    data2 = 24'h0;
    m_run = 0; m_n = 0; m_k = 0; m_raw = 0; fifo_ptr = 0;
    p1 = idle(); p2 = idle();
    f_valid = 0; f_cyc = 0; f_rd = 0; f_den = 0; f_hdlow = 0; f_vdlow = 0;
    cyc2 = 0; n_fs2 = 0; chk_next2 = 0; done2 = 0; prev_cnt2 = '0; prev_uf2 = 1'b0;

    // reset, then an empty FIFO for 100 clocks before data arrives
    repeat (3) cyc(1'b1, 1'b0);
    repeat (100) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("run_entry_fs", fs, 1);

    // FIFO always ready
    repeat (2 * FRAME + 5) cyc(1'b0, 1'b1);

    // random FIFO starvation
    repeat (3 * FRAME) cyc($urandom_range(0, 3) == 0, 1'b1);

    // five-pixel starvation burst mid-line
    run_to(0, 1'b0);
    run_to((VS + VB + 1) * HT + HS + HB + 2, 1'b0);
    repeat (5) cyc(1'b1, 1'b1);
    run_to(0, 1'b0);
    chk("burst_cnt", ucnt, 5);
    chk("burst_flag", uf, 1);
    cyc(1'b0, 1'b1);
    chk("burst_cnt_clr", ucnt, 0);
    chk("burst_flag_clr", uf, 0);

    // mid-frame reset for three clocks
    run_to((VT / 2) * HT + HT / 2, 1'b1);
    repeat (3) cyc(1'b0, 1'b0);
    chk("rst_hd", hd, 1);
    chk("rst_den", den, 0);
    repeat (4) cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("restart_fs", fs, 1);
    repeat (2 * FRAME) cyc(1'b0, 1'b1);

    // keep running until the saturation instance finishes its first frame
    guard = 0;
    while (!done2 && guard < 75000) begin
      cyc($urandom_range(0, 7) == 0, 1'b1);
      guard++;
    end
    chk("sat_done", done2, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
